panel_input_ctrl: RTL and testbench
===================================

PANEL_INPUT_CTRL -- requirements
Module: panel_input_ctrl

Interface
REQ-001 Parameter: DB_CNT, 4, consecutive stable cycles required before a debounced input changes (legal range 2..255).
REQ-002 Clocking: one clock `clk`; reset `reset` is asynchronous and active-high.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_power  input  1  raw, asynchronous, bouncy power-select button (1 = pressed).
REQ-006 btn_time  input  1  raw time-select button.
REQ-007 btn_start  input  1  raw start button.
REQ-008 btn_cancel  input  1  raw cancel button.
REQ-009 door_sw  input  1  raw door switch (1 = open).
REQ-010 finished  input  1  cook-complete level from the oven controller.
REQ-011 full_power / half_power  output  1 each  power selection; one-hot or both 0.
REQ-012 s30 / s60 / s120  output  1 each  time selection; one-hot or all 0.
REQ-013 time_set  output  1  high iff one of s30/s60/s120 is high.
REQ-014 start  output  1  cook request level.
REQ-015 door_open  output  1  debounced door switch level.

Function
REQ-016 Each raw input SHALL pass a 2-FF synchronizer, then a debouncer whose output changes only after the synchronized value has differed from it for DB_CNT consecutive cycles; any intermediate match SHALL reset the count.
REQ-017 A button "press" SHALL be a single-cycle 0->1 edge of the debounced level; release SHALL have no effect.
REQ-018 All selection outputs SHALL be registered and SHALL update on the cycle after the debounced press edge.
REQ-019 Total latency from a clean raw edge to an output change SHALL be 2 + DB_CNT + 1 cycles.
REQ-020 Power FSM states: PWR_NONE -> (press) PWR_FULL -> (press) PWR_HALF -> (press) PWR_FULL.
REQ-021 Time FSM states: T_NONE -> T_30 -> T_60 -> T_120 -> T_30, advancing one state per btn_time press.
REQ-022 A start press SHALL set start=1 only if the power state is not PWR_NONE, time_set=1 and door_open=0; otherwise it SHALL be ignored.
REQ-023 While start=1, power and time presses SHALL be ignored (selections locked).
REQ-024 While start=1, door_open=1 SHALL NOT clear start (the oven pauses and resumes on close).
REQ-025 A rising edge of finished SHALL clear start and return the time FSM to T_NONE; power selection SHALL be retained.
REQ-026 A cancel press SHALL return power, time and start to their reset values.
REQ-027 Priority within one cycle: cancel > finished edge > start press > power/time press.
REQ-028 door_open SHALL follow the debounced door_sw directly, with no edge detection.

Reset
REQ-029 Asserting reset SHALL immediately force all outputs to 0, power to PWR_NONE, time to T_NONE, and clear the synchronizers, debounced levels and counters to 0, including mid-debounce or while start=1.
REQ-030 After deassertion, inputs already held high SHALL debounce to 1 without producing a press edge (the edge detector history resets to the synchronized value).

Structure
REQ-031 Package oven_pkg SHALL hold power_e {PWR_NONE, PWR_FULL, PWR_HALF}, time_e {T_NONE, T_30, T_60, T_120} and DB_CNT_DEFAULT=4.
REQ-032 Sub-module `debounce` (synchronizer, counter and level register, parameterized by DB_CNT) SHALL be instantiated five times; edge detection and the FSMs SHALL reside in panel_input_ctrl.

Verification (DB_CNT=4, 20 ns clock)
REQ-033 Reset, then one clean btn_power press -> full_power=1 exactly 7 cycles after the raw edge; a second press -> half_power=1, full_power=0.
REQ-034 btn_time pressed 4 times -> s30, s60, s120, s30 in sequence, with time_set=1 throughout.
REQ-035 Raw btn_start toggling every 2 cycles for 20 cycles (bounce) -> no start assertion; then held stable -> start=1 at raw edge + 7 cycles, given FULL and S30 selected and door closed.
REQ-036 door_sw=1 while start=1 -> door_open=1 and start stays 1; btn_power press in that interval -> power unchanged.
REQ-037 finished rises while start=1 -> next cycle start=0, time_set=0, full_power still 1.
REQ-038 Cancel press and finished edge in the same cycle, and reset asserted mid-debounce -> all outputs 0 and no spurious press after release.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared types and constants for the oven front-panel input logic.
// The power and time selections advance cyclically through these state sequences.
package oven_pkg;

  localparam int unsigned DB_CNT_DEFAULT = 4;

  typedef enum logic [1:0] {PWR_NONE, PWR_FULL, PWR_HALF} power_e;
  typedef enum logic [1:0] {T_NONE, T_30, T_60, T_120} time_e;

  // Bit positions of the debounced inputs; buttons first, door switch last.
  localparam int unsigned BTN_POWER  = 0;
  localparam int unsigned BTN_TIME   = 1;
  localparam int unsigned BTN_START  = 2;
  localparam int unsigned BTN_CANCEL = 3;
  localparam int unsigned NUM_BTN    = 4;
  localparam int unsigned IN_DOOR    = 4;

  function automatic power_e power_next(input power_e cur);
    case (cur)
      PWR_NONE: return PWR_FULL;
      PWR_FULL: return PWR_HALF;
      default:  return PWR_FULL;
    endcase
  endfunction

  function automatic time_e time_next(input time_e cur);
    case (cur)
      T_NONE:  return T_30;
      T_30:    return T_60;
      T_60:    return T_120;
      default: return T_30;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a debouncer: the level flips only after the
// synchronized input has disagreed with it for DB_CNT consecutive cycles.
module debounce #(
  parameter int unsigned DB_CNT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [7:0] CNT_LAST = 8'(DB_CNT - 1);

  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // Any cycle where the input agrees with the level restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync[1] == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= r_sync[1];
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/panel_input_ctrl.sv
// Oven front panel: debounces the buttons and door switch, turns button presses
// into power/time selections and a cook request, and clears them on cancel/finish.
module panel_input_ctrl
  import oven_pkg::*;
#(
  parameter int unsigned DB_CNT = DB_CNT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_power,
  input  logic btn_time,
  input  logic btn_start,
  input  logic btn_cancel,
  input  logic door_sw,
  input  logic finished,
  output logic full_power,
  output logic half_power,
  output logic s30,
  output logic s60,
  output logic s120,
  output logic time_set,
  output logic start,
  output logic door_open
);

  localparam logic [9:0] BOOT_LEN = 10'(DB_CNT + 3);

  logic [NUM_BTN:0]   w_raw;
  logic [NUM_BTN:0]   w_lvl;
  logic [NUM_BTN-1:0] r_hist;
  logic [NUM_BTN-1:0] w_press;
  logic [9:0]         r_boot;
  logic               w_boot_done;
  logic               r_fin_q;
  logic               w_fin_edge;
  logic               w_start_ok;

  power_e r_pwr;
  power_e w_pwr_nxt;
  time_e  r_time;
  time_e  w_time_nxt;
  logic   r_start;
  logic   w_start_nxt;

  assign w_raw = {door_sw, btn_cancel, btn_start, btn_time, btn_power};

  for (genvar g = 0; g <= NUM_BTN; g = g + 1) begin : g_db
    debounce #(.DB_CNT(DB_CNT)) u_db (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_raw  (w_raw[g]),
      .o_level(w_lvl[g])
    );
  end

  // Presses are masked until every debouncer has settled on the input level it
  // saw at reset release, so a button held through reset never reads as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist  <= '0;
      r_boot  <= '0;
      r_fin_q <= 1'b0;
    end else begin
      r_hist  <= w_lvl[NUM_BTN-1:0];
      r_fin_q <= finished;
      if (!w_boot_done) begin
        r_boot <= r_boot + 10'd1;
      end
    end
  end

  assign w_boot_done = (r_boot == BOOT_LEN);
  assign w_press     = w_lvl[NUM_BTN-1:0] & ~r_hist & {NUM_BTN{w_boot_done}};
  assign w_fin_edge  = finished & ~r_fin_q;
  assign w_start_ok  = !r_start && (r_pwr != PWR_NONE) && (r_time != T_NONE)
                       && !w_lvl[IN_DOOR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwr   <= PWR_NONE;
      r_time  <= T_NONE;
      r_start <= 1'b0;
    end else begin
      r_pwr   <= w_pwr_nxt;
      r_time  <= w_time_nxt;
      r_start <= w_start_nxt;
    end
  end

  // Priority: cancel, then finish edge, then start, then selections (locked while cooking).
  always_comb begin
    w_pwr_nxt   = r_pwr;
    w_time_nxt  = r_time;
    w_start_nxt = r_start;
    if (w_press[BTN_CANCEL]) begin
      w_pwr_nxt   = PWR_NONE;
      w_time_nxt  = T_NONE;
      w_start_nxt = 1'b0;
    end else if (w_fin_edge) begin
      w_time_nxt  = T_NONE;
      w_start_nxt = 1'b0;
    end else if (w_press[BTN_START] && w_start_ok) begin
      w_start_nxt = 1'b1;
    end else if (!r_start) begin
      if (w_press[BTN_POWER]) begin
        w_pwr_nxt = power_next(r_pwr);
      end
      if (w_press[BTN_TIME]) begin
        w_time_nxt = time_next(r_time);
      end
    end
  end

  assign full_power = (r_pwr == PWR_FULL);
  assign half_power = (r_pwr == PWR_HALF);
  assign s30        = (r_time == T_30);
  assign s60        = (r_time == T_60);
  assign s120       = (r_time == T_120);
  assign time_set   = (r_time != T_NONE);
  assign start      = r_start;
  assign door_open  = w_lvl[IN_DOOR];

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Directed-vector bench for panel_input_ctrl with DB_CNT=4 and a 20 ns clock.
module tb_panel_input_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic btn_power, btn_time, btn_start, btn_cancel, door_sw, finished;
  logic full_power, half_power, s30, s60, s120, time_set, start, door_open;
  logic [7:0] w_out;

  panel_input_ctrl #(.DB_CNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_power (btn_power),
    .btn_time  (btn_time),
    .btn_start (btn_start),
    .btn_cancel(btn_cancel),
    .door_sw   (door_sw),
    .finished  (finished),
    .full_power(full_power),
    .half_power(half_power),
    .s30       (s30),
    .s60       (s60),
    .s120      (s120),
    .time_set  (time_set),
    .start     (start),
    .door_open (door_open)
  );

  always #10 clk = ~clk;

  assign w_out = {full_power, half_power, s30, s60, s120, time_set, start, door_open};

  // Input bits {power, time, start, cancel, door, finished}
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] T = 6'b010000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] C = 6'b000100;
  localparam logic [5:0] D = 6'b000010;
  localparam logic [5:0] F = 6'b000001;
  localparam logic [5:0] NONE_IN = 6'b000000;

  // Output bits {full, half, s30, s60, s120, time_set, start, door_open}
  localparam logic [7:0] O0   = 8'b0000_0000;
  localparam logic [7:0] FULL = 8'b1000_0000;
  localparam logic [7:0] HALF = 8'b0100_0000;
  localparam logic [7:0] S30  = 8'b0010_0100;
  localparam logic [7:0] S60  = 8'b0001_0100;
  localparam logic [7:0] S120 = 8'b0000_1100;
  localparam logic [7:0] RUN  = 8'b0000_0010;
  localparam logic [7:0] DOOR = 8'b0000_0001;

  typedef struct {
    logic [5:0]  in;
    int unsigned n;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic set_in(input logic [5:0] v);
    {btn_power, btn_time, btn_start, btn_cancel, door_sw, finished} = v;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    n_tests++;
    if (w_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, w_out, exp);
    end
  endtask

  function automatic void add(input logic [5:0] in, input int unsigned n,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.in = in; v.n = n; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].in);
      repeat (tbl[i].n) @(negedge clk);
      check(tbl[i].name, tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    reset = 1'b1;
    set_in(NONE_IN);
    repeat (3) @(negedge clk);
    check("reset", O0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_reset_idle", O0);

    // Selection sequencing and start qualification
    add(P,     6, O0,               "pwr_lat_6");
    add(P,     1, FULL,             "pwr_lat_7");
    add(NONE_IN, 8, FULL,           "pwr_release");
    add(P,     8, HALF,             "pwr_half");
    add(NONE_IN, 8, HALF,           "pwr_half_rel");
    add(S,     8, HALF,             "start_no_time");
    add(NONE_IN, 8, HALF,           "start_no_time_rel");
    add(T,     8, HALF | S30,       "time_30");
    add(NONE_IN, 8, HALF | S30,     "time_30_rel");
    add(T,     8, HALF | S60,       "time_60");
    add(NONE_IN, 8, HALF | S60,     "time_60_rel");
    add(T,     8, HALF | S120,      "time_120");
    add(NONE_IN, 8, HALF | S120,    "time_120_rel");
    add(T,     8, HALF | S30,       "time_wrap_30");
    add(NONE_IN, 8, HALF | S30,     "time_wrap_rel");
    add(P,     8, FULL | S30,       "pwr_wrap_full");
    add(NONE_IN, 8, FULL | S30,     "pwr_wrap_rel");
    add(D,     8, FULL | S30 | DOOR, "door_open");
    add(D | S, 8, FULL | S30 | DOOR, "start_door_blocked");
    add(D,     8, FULL | S30 | DOOR, "start_door_rel");
    add(NONE_IN, 8, FULL | S30,     "door_close");
    run_table();

    // Bouncing start button never settles
    for (int k = 0; k < 10; k++) begin
      set_in((k % 2 == 0) ? S : NONE_IN);
      repeat (2) @(negedge clk);
      check("start_bounce", FULL | S30);
    end
    set_in(S);
    repeat (6) @(negedge clk);
    check("start_lat_6", FULL | S30);
    @(negedge clk);
    check("start_lat_7", FULL | S30 | RUN);

    add(NONE_IN, 8, FULL | S30 | RUN,       "start_release");
    add(D,     8, FULL | S30 | RUN | DOOR,  "door_while_run");
    add(D | P, 8, FULL | S30 | RUN | DOOR,  "pwr_locked");
    add(D,     8, FULL | S30 | RUN | DOOR,  "pwr_locked_rel");
    add(D | T, 8, FULL | S30 | RUN | DOOR,  "time_locked");
    add(D,     8, FULL | S30 | RUN | DOOR,  "time_locked_rel");
    add(NONE_IN, 8, FULL | S30 | RUN,       "door_close_run");
    add(F,     1, FULL,                     "finish_edge");
    add(F,     3, FULL,                     "finish_level");
    add(NONE_IN, 2, FULL,                   "finish_low");
    add(T,     8, FULL | S30,               "rearm_time");
    add(NONE_IN, 8, FULL | S30,             "rearm_time_rel");
    add(S,     8, FULL | S30 | RUN,         "restart");
    add(NONE_IN, 8, FULL | S30 | RUN,       "restart_rel");
    add(C,     6, FULL | S30 | RUN,         "cancel_lat_6");
    add(C | F, 1, O0,                       "cancel_beats_finish");
    add(NONE_IN, 8, O0,                     "cancel_release");
    add(P,     8, FULL,                     "pre_rst_pwr");
    add(NONE_IN, 8, FULL,                   "pre_rst_pwr_rel");
    add(T,     8, FULL | S30,               "pre_rst_time");
    add(NONE_IN, 8, FULL | S30,             "pre_rst_time_rel");
    add(S,     8, FULL | S30 | RUN,         "pre_rst_start");
    add(NONE_IN, 8, FULL | S30 | RUN,       "pre_rst_start_rel");
    run_table();

    // Reset in the middle of a power debounce while cooking
    set_in(P);
    repeat (3) @(negedge clk);
    #5 reset = 1'b1;
    #1 check("rst_async", O0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_release", O0);
    repeat (20) @(negedge clk);
    check("rst_no_spurious", O0);
    set_in(NONE_IN);
    repeat (8) @(negedge clk);
    check("rst_btn_release", O0);
    set_in(P);
    repeat (8) @(negedge clk);
    check("rst_alive", FULL);
    set_in(NONE_IN);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
